// File: rtl/switch_conditioner.sv
// Raw slide-switch conditioning: two-flop sync, whole-vector debounce,
// and a go/snapshot handshake for the register stage.
module switch_conditioner #(
  parameter int SWITCH_WIDTH    = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic [SWITCH_WIDTH-1:0] sw_raw,
  input  logic                    wait_req,
  output logic [SWITCH_WIDTH-2:0] switches,
  output logic                    go,
  output logic [SWITCH_WIDTH-1:0] sw_stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);

  typedef enum logic {
    WAIT_HIGH,
    WAIT_LOW
  } state_t;

  logic [SWITCH_WIDTH-1:0] sync1;
  logic [SWITCH_WIDTH-1:0] sync2;
  logic [SWITCH_WIDTH-1:0] sync2_prev;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_next;
  logic                    changed;
  logic                    differs;
  logic                    h;
  state_t                  state;

  assign changed = sync2 != sync2_prev;
  assign differs = sync2 != sw_stable;
  // consecutive samples of the current sync2 value, this cycle included
  assign cnt_next = changed ? CW'(1) : cnt + CW'(1);
  assign h = sw_stable[SWITCH_WIDTH-1];

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync1      <= '0;
      sync2      <= '0;
      sync2_prev <= '0;
      sw_stable  <= '0;
      cnt        <= '0;
    end else begin
      sync1      <= sw_raw;
      sync2      <= sync1;
      sync2_prev <= sync2;
      if (!differs) begin
        cnt <= '0;
      end else if (cnt_next == LAST) begin
        sw_stable <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= WAIT_HIGH;
      switches <= '0;
      go       <= 1'b0;
    end else begin
      go <= 1'b0;
      unique case (state)
        WAIT_HIGH: begin
          if (h) begin
            state <= WAIT_LOW;
            // a press made before the processor waits is consumed
            if (wait_req) begin
              switches <= sw_stable[SWITCH_WIDTH-2:0];
              go       <= 1'b1;
            end
          end
        end
        WAIT_LOW: begin
          if (!h) state <= WAIT_HIGH;
        end
        default: state <= WAIT_HIGH;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with DEBOUNCE_CYCLES=4,
// SWITCH_WIDTH=10: vector table plus multi-cycle corner sequences.
module tb_switch_conditioner;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [9:0] sw_raw;
  logic       wait_req;
  logic [8:0] switches;
  logic       go;
  logic [9:0] sw_stable;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic [9:0] raw;
    logic       wr;
    logic [8:0] sw;
    logic       g;
    logic [9:0] st;
  } vec_t;

  vec_t tbl[$];

  switch_conditioner #(
    .SWITCH_WIDTH(10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .sw_raw(sw_raw),
    .wait_req(wait_req),
    .switches(switches),
    .go(go),
    .sw_stable(sw_stable)
  );

  always #5 clk = ~clk;

  task automatic hold(input int n, input logic rst,
                      input logic [9:0] raw, input logic wr,
                      input logic [8:0] sw, input logic g,
                      input logic [9:0] st);
    vec_t v;
    v.rst = rst;
    v.raw = raw;
    v.wr  = wr;
    v.sw  = sw;
    v.g   = g;
    v.st  = st;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h want %h", name, idx, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] r;

    // reset, release with all switches up, then handshake and data change
    hold(3, 0, 10'h3FF, 0, 9'h000, 0, 10'h000);
    hold(5, 1, 10'h3FF, 0, 9'h000, 0, 10'h000);
    hold(2, 1, 10'h3FF, 0, 9'h000, 0, 10'h3FF);
    hold(5, 1, 10'h0A5, 1, 9'h000, 0, 10'h3FF);
    hold(2, 1, 10'h0A5, 1, 9'h000, 0, 10'h0A5);
    hold(5, 1, 10'h2A5, 1, 9'h000, 0, 10'h0A5);
    hold(1, 1, 10'h2A5, 1, 9'h000, 0, 10'h2A5);
    hold(1, 1, 10'h2A5, 1, 9'h0A5, 1, 10'h2A5);
    hold(1, 1, 10'h2A5, 1, 9'h0A5, 0, 10'h2A5);
    hold(5, 1, 10'h0A5, 1, 9'h0A5, 0, 10'h2A5);
    hold(2, 1, 10'h0A5, 1, 9'h0A5, 0, 10'h0A5);
    hold(5, 1, 10'h1FF, 1, 9'h0A5, 0, 10'h0A5);
    hold(3, 1, 10'h1FF, 1, 9'h0A5, 0, 10'h1FF);

    foreach (tbl[i]) begin
      n_reset  = tbl[i].rst;
      sw_raw   = tbl[i].raw;
      wait_req = tbl[i].wr;
      cyc();
      chk("tbl_switches", i, 10'(switches), 10'(tbl[i].sw));
      chk("tbl_go", i, 10'(go), 10'(tbl[i].g));
      chk("tbl_stable", i, sw_stable, tbl[i].st);
    end

    // bounce rejection on bit 0
    sw_raw = 10'h000;
    repeat (8) cyc();
    chk("bounce_pre", 0, sw_stable, 10'h000);
    r = 10'h000;
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) r[0] = ~r[0];
      sw_raw = r;
      cyc();
      chk("bounce_toggle", c, sw_stable, 10'h000);
    end
    sw_raw = 10'h001;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("bounce_settle", i, sw_stable, (i == 5) ? 10'h001 : 10'h000);
    end

    // early press is consumed, not queued
    wait_req = 1'b0;
    sw_raw   = 10'h201;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("early_go", i, 10'(go), 10'h000);
    end
    chk("early_stable", 0, sw_stable, 10'h201);
    wait_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("early_wait_go", i, 10'(go), 10'h000);
    end
    chk("early_switches", 0, 10'(switches), 10'h0A5);
    sw_raw = 10'h033;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("early_low_go", i, 10'(go), 10'h000);
    end
    sw_raw = 10'h233;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("repress_go", i, 10'(go), (i == 6) ? 10'h001 : 10'h000);
    end
    chk("repress_switches", 0, 10'(switches), 10'h033);

    // reset in the middle of a pending change
    n_reset = 1'b0;
    sw_raw  = 10'h000;
    cyc();
    cyc();
    chk("rst_switches", 0, 10'(switches), 10'h000);
    chk("rst_go", 0, 10'(go), 10'h000);
    chk("rst_stable", 0, sw_stable, 10'h000);
    n_reset = 1'b1;
    repeat (8) cyc();
    chk("rst_idle", 0, sw_stable, 10'h000);
    sw_raw = 10'h155;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("mid_pending", i, sw_stable, 10'h000);
    end
    n_reset = 1'b0;
    cyc();
    chk("mid_reset", 0, sw_stable, 10'h000);
    n_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("mid_redo", i, sw_stable, (i == 5) ? 10'h155 : 10'h000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
